blit_addr_walker: RTL and testbench

Parametrised successor to the blitter pixel address generator. Holds NCHAN independent window channels (x/y pointer, base, pitch, pixsize, width, zoffset). After a start command it walks a rectangular inner/outer loop. For each pixel it emits one registered address per enabled channel over a valid/ready handshake, then steps each channel's pointers. It sits between the blitter register file and the memory-request sequencer.

---
 rtl/blit_pkg.sv | 38 +++
 rtl/blit_addr_calc.sv | 55 +++++
 rtl/blit_addr_walker.sv | 179 +++++++++++++++++
 tb/tb_blit_addr_walker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared types for the blitter address walker: pitch codes, FSM states,
// per-channel window configuration and the pixel-size clamp.
package blit_pkg;

    typedef enum logic [1:0] {
        PITCH_X1 = 2'd0,
        PITCH_X2 = 2'd1,
        PITCH_X4 = 2'd2,
        PITCH_X3 = 2'd3
    } pitch_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic        en;
        logic [15:0] x;
        logic [15:0] y;
        logic [20:0] base;
        logic [1:0]  pitch;
        logic [2:0]  pixsize;
        logic [5:0]  width;
        logic [1:0]  zoffset;
        logic        zaddr;
        logic [15:0] xstep;
        logic [15:0] xadd;
        logic [15:0] yadd;
    } chan_cfg_t;

    // Codes 6 and 7 alias onto 4 and 5 (legacy pixel-size decode).
    function automatic logic [2:0] clamp_pixsize(input logic [2:0] ps);
        return (ps > 3'd5) ? ps - 3'd2 : ps;
    endfunction

endpackage

// File: rtl/blit_addr_calc.sv
// Combinational pixel address equation for one window channel:
// row offset from y and the mantissa/exponent width, then scale by pixel size and pitch.
module blit_addr_calc
    import blit_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [20:0] base,
    input  logic [1:0]  pitch,
    input  logic [2:0]  pixsize,
    input  logic [5:0]  width,
    input  logic [1:0]  zoffset,
    input  logic        zaddr,
    output logic [23:0] address,
    output logic [2:0]  pixa
);

    logic [1:0]  mant;
    logic [3:0]  expo;
    logic [14:0] ym;
    logic [25:0] ysh;
    logic [23:0] row;
    logic [24:0] pa;
    logic [29:0] bitaddr;
    logic [20:0] phrase;
    logic [20:0] scaled;
    logic [20:0] zadd;
    logic [20:0] addr21;

    always_comb begin
        mant    = width[1:0];
        expo    = width[5:2];
        ym      = {3'b0, y[11:0]} * {12'b0, 1'b1, mant};
        ysh     = {11'b0, ym} << expo;
        // Exponents of 12 and above describe windows too wide for the y term.
        row     = (expo >= 4'd12) ? 24'd0 : ysh[25:2];
        pa      = {1'b0, row} + {9'b0, x};
        bitaddr = {5'b0, pa} << clamp_pixsize(pixsize);
        phrase  = bitaddr[26:6];
        case (pitch_e'(pitch))
            PITCH_X1: scaled = phrase;
            PITCH_X2: scaled = phrase << 1;
            PITCH_X4: scaled = phrase << 2;
            default:  scaled = phrase + (phrase << 1);
        endcase
        zadd    = zaddr ? {19'b0, zoffset} : 21'd0;
        addr21  = base + scaled + zadd;
        address = {addr21, bitaddr[5:3]};
        pixa    = bitaddr[2:0];
    end

    logic unused_bits;
    assign unused_bits = ^{y[15:12], ysh[1:0], bitaddr[29:27]};

endmodule

// File: rtl/blit_addr_walker.sv
// Multi-channel blitter address walker: steps a rectangle of pixels and
// issues one registered address per enabled channel per pixel over valid/ready.
module blit_addr_walker
    import blit_pkg::*;
#(
    parameter int NCHAN = 2,
    parameter int CW    = 2,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             cfg_we,
    input  logic [CW-1:0]    cfg_ch,
    input  logic             cfg_en,
    input  logic [15:0]      cfg_x,
    input  logic [15:0]      cfg_y,
    input  logic [20:0]      cfg_base,
    input  logic [1:0]       cfg_pitch,
    input  logic [2:0]       cfg_pixsize,
    input  logic [5:0]       cfg_width,
    input  logic [1:0]       cfg_zoffset,
    input  logic             cfg_zaddr,
    input  logic [15:0]      cfg_xstep,
    input  logic [15:0]      cfg_xadd,
    input  logic [15:0]      cfg_yadd,
    input  logic [CNT_W-1:0] inner_cnt,
    input  logic [CNT_W-1:0] outer_cnt,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             addr_valid,
    input  logic             addr_ready,
    output logic [23:0]      address,
    output logic [2:0]       pixa,
    output logic [CW-1:0]    addr_ch,
    output logic             last,
    output logic             done
);

    state_e           state, state_nxt;
    chan_cfg_t        chan [NCHAN];
    chan_cfg_t        cur_cfg;
    logic [CW-1:0]    cur_ch, first_en, next_ch;
    logic             any_en, has_next;
    logic [CNT_W-1:0] inner_rem, outer_rem, inner_load;
    logic [23:0]      calc_addr;
    logic [2:0]       calc_pixa;
    logic             walk_ok, row_end, final_pix;
    logic             do_start, do_empty, do_load, do_accept;

    // Lowest enabled channel, next enabled channel above the current one,
    // and the config of the current channel.
    always_comb begin
        any_en   = 1'b0;
        first_en = '0;
        has_next = 1'b0;
        next_ch  = '0;
        cur_cfg  = chan[0];
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (chan[i].en) begin
                any_en   = 1'b1;
                first_en = CW'(i);
                if (i > int'(cur_ch)) begin
                    has_next = 1'b1;
                    next_ch  = CW'(i);
                end
            end
            if (CW'(i) == cur_ch) cur_cfg = chan[i];
        end
    end

    assign walk_ok   = any_en && (inner_cnt != '0) && (outer_cnt != '0);
    assign row_end   = (inner_rem == CNT_W'(1));
    assign final_pix = row_end && (outer_rem == CNT_W'(1));
    assign busy      = (state != S_IDLE);

    blit_addr_calc u_calc (
        .x       (cur_cfg.x),
        .y       (cur_cfg.y),
        .base    (cur_cfg.base),
        .pitch   (cur_cfg.pitch),
        .pixsize (cur_cfg.pixsize),
        .width   (cur_cfg.width),
        .zoffset (cur_cfg.zoffset),
        .zaddr   (cur_cfg.zaddr),
        .address (calc_addr),
        .pixa    (calc_pixa)
    );

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && walk_ok) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (addr_ready) state_nxt = last ? S_IDLE : S_ISSUE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        do_start  = (state == S_IDLE) && start && !abort && walk_ok;
        do_empty  = (state == S_IDLE) && start && !abort && !walk_ok;
        do_load   = (state == S_ISSUE) && !abort;
        do_accept = (state == S_WAIT) && addr_ready && !abort;
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            for (int i = 0; i < NCHAN; i++) chan[i] <= '0;
            cur_ch     <= '0;
            inner_rem  <= '0;
            outer_rem  <= '0;
            inner_load <= '0;
            addr_valid <= 1'b0;
            address    <= '0;
            pixa       <= '0;
            addr_ch    <= '0;
            last       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= do_empty || (do_accept && last);

            for (int i = 0; i < NCHAN; i++) begin
                if ((state == S_IDLE) && cfg_we && (CW'(i) == cfg_ch)) begin
                    chan[i] <= '{en: cfg_en, x: cfg_x, y: cfg_y, base: cfg_base,
                                 pitch: cfg_pitch, pixsize: cfg_pixsize, width: cfg_width,
                                 zoffset: cfg_zoffset, zaddr: cfg_zaddr, xstep: cfg_xstep,
                                 xadd: cfg_xadd, yadd: cfg_yadd};
                end
                // Pointers step once per pixel, after its last channel is taken.
                if (do_accept && !has_next && chan[i].en) begin
                    chan[i].x <= chan[i].x + (row_end ? chan[i].xadd : chan[i].xstep);
                    if (row_end) chan[i].y <= chan[i].y + chan[i].yadd;
                end
            end

            if (do_start) begin
                inner_rem  <= inner_cnt;
                outer_rem  <= outer_cnt;
                inner_load <= inner_cnt;
                cur_ch     <= first_en;
            end

            if (do_load) begin
                address    <= calc_addr;
                pixa       <= calc_pixa;
                addr_ch    <= cur_ch;
                last       <= final_pix && !has_next;
                addr_valid <= 1'b1;
            end

            if (do_accept) begin
                addr_valid <= 1'b0;
                last       <= 1'b0;
                cur_ch     <= has_next ? next_ch : first_en;
                if (!has_next) begin
                    if (row_end) begin
                        inner_rem <= inner_load;
                        outer_rem <= outer_rem - CNT_W'(1);
                    end else begin
                        inner_rem <= inner_rem - CNT_W'(1);
                    end
                end
            end

            if (abort) begin
                addr_valid <= 1'b0;
                last       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blit_addr_walker.sv
// Directed bench for blit_addr_walker: single-address vector table, then
// multi-channel walk, stall/abort, start+abort and async reset sequences.
module tb_blit_addr_walker;

    localparam int NCHAN = 2;
    localparam int CW    = 2;
    localparam int CNT_W = 16;

    logic             sys_clk = 1'b0;
    logic             resetl = 1'b1;
    logic             cfg_we = 1'b0;
    logic [CW-1:0]    cfg_ch = '0;
    logic             cfg_en = 1'b0;
    logic [15:0]      cfg_x = '0, cfg_y = '0;
    logic [20:0]      cfg_base = '0;
    logic [1:0]       cfg_pitch = '0;
    logic [2:0]       cfg_pixsize = '0;
    logic [5:0]       cfg_width = '0;
    logic [1:0]       cfg_zoffset = '0;
    logic             cfg_zaddr = 1'b0;
    logic [15:0]      cfg_xstep = '0, cfg_xadd = '0, cfg_yadd = '0;
    logic [CNT_W-1:0] inner_cnt = '0, outer_cnt = '0;
    logic             start = 1'b0, abort = 1'b0, addr_ready = 1'b0;
    logic             busy, addr_valid, last, done;
    logic [23:0]      address;
    logic [2:0]       pixa;
    logic [CW-1:0]    addr_ch;

    blit_addr_walker #(.NCHAN(NCHAN), .CW(CW), .CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .resetl(resetl), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_en(cfg_en), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_base(cfg_base),
        .cfg_pitch(cfg_pitch), .cfg_pixsize(cfg_pixsize), .cfg_width(cfg_width),
        .cfg_zoffset(cfg_zoffset), .cfg_zaddr(cfg_zaddr), .cfg_xstep(cfg_xstep),
        .cfg_xadd(cfg_xadd), .cfg_yadd(cfg_yadd), .inner_cnt(inner_cnt),
        .outer_cnt(outer_cnt), .start(start), .abort(abort), .busy(busy),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .address(address),
        .pixa(pixa), .addr_ch(addr_ch), .last(last), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [20:0] base;
        logic [2:0]  pixsize;
        logic [5:0]  width;
        logic [1:0]  pitch;
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  zoff;
        logic        zaddr;
        logic [23:0] exp_addr;
        logic [2:0]  exp_pixa;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_ch(input logic [CW-1:0] ch, input logic en,
                          input logic [15:0] x, input logic [15:0] y,
                          input logic [20:0] base, input logic [1:0] pitch,
                          input logic [2:0] ps, input logic [5:0] w,
                          input logic [1:0] zo, input logic za,
                          input logic [15:0] xs, input logic [15:0] xa,
                          input logic [15:0] ya);
        cfg_ch = ch; cfg_en = en; cfg_x = x; cfg_y = y; cfg_base = base;
        cfg_pitch = pitch; cfg_pixsize = ps; cfg_width = w; cfg_zoffset = zo;
        cfg_zaddr = za; cfg_xstep = xs; cfg_xadd = xa; cfg_yadd = ya;
        cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
    endtask

    task automatic start_walk(input logic [CNT_W-1:0] ic, input logic [CNT_W-1:0] oc);
        inner_cnt = ic;
        outer_cnt = oc;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic setup_two;
        set_ch(2'd0, 1'b1, 16'd3, 16'd2, 21'h1000, 2'd0, 3'd4, 6'h18, 2'd0, 1'b0,
               16'd1, 16'hFFFE, 16'd1);
        set_ch(2'd1, 1'b1, 16'd0, 16'd0, 21'h100, 2'd0, 3'd3, 6'h30, 2'd0, 1'b0,
               16'd1, 16'hFFFE, 16'd1);
    endtask

    logic [23:0]   exp_a [12];
    logic [CW-1:0] exp_c [12];

    initial begin
        vecs[0]  = '{21'h1000,   3'd4, 6'h18, 2'd0, 16'd3,  16'd2, 2'd0, 1'b0, 24'h8106, 3'd0};
        vecs[1]  = '{21'h1000,   3'd4, 6'h18, 2'd3, 16'd3,  16'd2, 2'd0, 1'b0, 24'h8306, 3'd0};
        vecs[2]  = '{21'h1000,   3'd4, 6'h18, 2'd2, 16'd3,  16'd2, 2'd0, 1'b0, 24'h8406, 3'd0};
        vecs[3]  = '{21'h1000,   3'd4, 6'h18, 2'd1, 16'd3,  16'd2, 2'd0, 1'b0, 24'h8206, 3'd0};
        vecs[4]  = '{21'h200,    3'd3, 6'h30, 2'd0, 16'd5,  16'd7, 2'd0, 1'b0, 24'h1005, 3'd0};
        vecs[5]  = '{21'h1000,   3'd4, 6'h18, 2'd0, 16'd3,  16'd2, 2'd2, 1'b1, 24'h8116, 3'd0};
        vecs[6]  = '{21'h1000,   3'd4, 6'h18, 2'd0, 16'd3,  16'd2, 2'd2, 1'b0, 24'h8106, 3'd0};
        vecs[7]  = '{21'h1000,   3'd6, 6'h18, 2'd0, 16'd3,  16'd2, 2'd0, 1'b0, 24'h8106, 3'd0};
        vecs[8]  = '{21'h0,      3'd0, 6'h30, 2'd0, 16'd13, 16'd0, 2'd0, 1'b0, 24'h000001, 3'd5};
        vecs[9]  = '{21'h10,     3'd3, 6'h0B, 2'd0, 16'd0,  16'd1, 2'd0, 1'b0, 24'h000087, 3'd0};
        vecs[10] = '{21'h1FFFFF, 3'd3, 6'h30, 2'd0, 16'd8,  16'd0, 2'd0, 1'b0, 24'h000000, 3'd0};
        vecs[11] = '{21'h0,      3'd7, 6'h30, 2'd0, 16'd1,  16'd0, 2'd0, 1'b0, 24'h000004, 3'd0};

        exp_a = '{24'h8106, 24'h800, 24'h8108, 24'h801, 24'h810A, 24'h802,
                  24'h8186, 24'h800, 24'h8188, 24'h801, 24'h818A, 24'h802};
        exp_c = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};

        #1 resetl = 1'b0;
        repeat (3) tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(addr_valid), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_pixa", 32'(pixa), 32'd0);
        chk("rst_ch", 32'(addr_ch), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        resetl = 1'b1;
        tick;

        // No channel enabled: done pulse, no walk.
        start_walk(16'd1, 16'd1);
        chk("noen_done", 32'(done), 32'd1);
        chk("noen_busy", 32'(busy), 32'd0);
        tick;
        chk("noen_done_clr", 32'(done), 32'd0);
        chk("noen_valid", 32'(addr_valid), 32'd0);

        for (int i = 0; i < 12; i++) begin
            set_ch(2'd0, 1'b1, vecs[i].x, vecs[i].y, vecs[i].base, vecs[i].pitch,
                   vecs[i].pixsize, vecs[i].width, vecs[i].zoff, vecs[i].zaddr,
                   16'd0, 16'd0, 16'd0);
            start_walk(16'd1, 16'd1);
            chk($sformatf("v%0d_lat", i), 32'(addr_valid), 32'd0);
            tick;
            chk($sformatf("v%0d_valid", i), 32'(addr_valid), 32'd1);
            chk($sformatf("v%0d_addr", i), 32'(address), 32'(vecs[i].exp_addr));
            chk($sformatf("v%0d_pixa", i), 32'(pixa), 32'(vecs[i].exp_pixa));
            chk($sformatf("v%0d_ch", i), 32'(addr_ch), 32'd0);
            chk($sformatf("v%0d_last", i), 32'(last), 32'd1);
            addr_ready = 1'b1;
            tick;
            addr_ready = 1'b0;
            chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
            chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
            tick;
            chk($sformatf("v%0d_done_clr", i), 32'(done), 32'd0);
        end

        // Two-channel 3x2 walk streaming with ready held high.
        begin
            int  idx;
            int  dones;
            logic prev_v;
            setup_two;
            addr_ready = 1'b1;
            start_walk(16'd3, 16'd2);
            idx = 0; dones = 0; prev_v = 1'b0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                if (addr_valid) begin
                    chk("walk_gap", 32'(prev_v), 32'd0);
                    if (idx < 12) begin
                        chk($sformatf("walk%0d_addr", idx), 32'(address), 32'(exp_a[idx]));
                        chk($sformatf("walk%0d_ch", idx), 32'(addr_ch), 32'(exp_c[idx]));
                        chk($sformatf("walk%0d_last", idx), 32'(last), (idx == 11) ? 32'd1 : 32'd0);
                    end
                    idx++;
                end
                if (done) dones++;
                prev_v = addr_valid;
                tick;
            end
            addr_ready = 1'b0;
            chk("walk_count", 32'(idx), 32'd12);
            chk("walk_dones", 32'(dones), 32'd1);
            chk("walk_busy", 32'(busy), 32'd0);
        end

        // Stall: outputs hold; config writes while busy are ignored; then abort.
        setup_two;
        start_walk(16'd3, 16'd2);
        tick;
        chk("stall_valid0", 32'(addr_valid), 32'd1);
        chk("stall_addr0", 32'(address), 32'h8106);
        for (int k = 0; k < 5; k++) begin
            if (k == 2)
                set_ch(2'd1, 1'b1, 16'd0, 16'd0, 21'h300, 2'd0, 3'd3, 6'h30, 2'd0, 1'b0,
                       16'd1, 16'hFFFE, 16'd1);
            else
                tick;
            chk($sformatf("stall%0d_valid", k), 32'(addr_valid), 32'd1);
            chk($sformatf("stall%0d_addr", k), 32'(address), 32'h8106);
            chk($sformatf("stall%0d_ch", k), 32'(addr_ch), 32'd0);
        end
        addr_ready = 1'b1;
        tick;
        addr_ready = 1'b0;
        chk("stall_drop", 32'(addr_valid), 32'd0);
        tick;
        chk("stall_next_valid", 32'(addr_valid), 32'd1);
        chk("stall_next_addr", 32'(address), 32'h800);
        chk("stall_next_ch", 32'(addr_ch), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_valid", 32'(addr_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        tick;
        chk("abort_done2", 32'(done), 32'd0);

        // start and abort together: abort wins.
        setup_two;
        start = 1'b1; abort = 1'b1;
        inner_cnt = 16'd1; outer_cnt = 16'd1;
        tick;
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_done", 32'(done), 32'd0);
        tick;
        chk("sa_valid", 32'(addr_valid), 32'd0);

        // Async reset mid-walk.
        setup_two;
        start_walk(16'd3, 16'd2);
        tick;
        chk("arst_pre_valid", 32'(addr_valid), 32'd1);
        #2 resetl = 1'b0;
        #1;
        chk("arst_valid", 32'(addr_valid), 32'd0);
        chk("arst_address", 32'(address), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ch", 32'(addr_ch), 32'd0);
        chk("arst_last", 32'(last), 32'd0);
        tick;
        resetl = 1'b1;
        tick;

        // Zero inner count: done pulse only.
        set_ch(2'd0, 1'b1, 16'd3, 16'd2, 21'h1000, 2'd0, 3'd4, 6'h18, 2'd0, 1'b0,
               16'd1, 16'd0, 16'd0);
        start_walk(16'd0, 16'd2);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_valid", 32'(addr_valid), 32'd0);
        chk("zero_busy", 32'(busy), 32'd0);
        tick;
        chk("zero_done_clr", 32'(done), 32'd0);
        repeat (2) tick;
        chk("zero_valid_late", 32'(addr_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
